// File: rtl/edge_setup.sv
// rtl/edge_setup.sv - per-frame triangle edge setup with shared shift-add multiplier and line stepping
module edge_setup #(
    parameter int W_E      = 20,
    parameter int H_LAST   = 799,
    parameter int V_ACTIVE = 480,
    parameter int V_LAST   = 524
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic signed [10:0]    x_v0,
    input  logic signed [10:0]    x_v1,
    input  logic signed [10:0]    x_v2,
    input  logic signed [10:0]    y_v0,
    input  logic signed [10:0]    y_v1,
    input  logic signed [10:0]    y_v2,
    output logic signed [W_E-1:0] y_screen_v0,
    output logic signed [W_E-1:0] y_screen_v1,
    output logic signed [W_E-1:0] y_screen_v2,
    output logic signed [W_E-1:0] e0_init_t1,
    output logic signed [W_E-1:0] e1_init_t1,
    output logic signed [W_E-1:0] e2_init_t1,
    output logic                  busy
);

    localparam logic [9:0] H_LAST_X   = 10'(H_LAST);
    localparam logic [9:0] V_ACTIVE_Y = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST_Y   = 10'(V_LAST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_MUL,
        S_COMMIT
    } state_t;

    state_t state_q, state_d;

    // Shadow vertices, captured only on the trigger edge
    logic signed [10:0]    xs_q [3];
    logic signed [10:0]    xs_d [3];
    logic signed [10:0]    ys_q [3];
    logic signed [10:0]    ys_d [3];

    // Edge deltas; dx stays live after commit for line stepping
    logic signed [11:0]    dx_q [3];
    logic signed [11:0]    dx_d [3];
    logic signed [11:0]    dy_q [3];
    logic signed [11:0]    dy_d [3];

    logic signed [W_E-1:0] acc_q [3];
    logic signed [W_E-1:0] acc_d [3];
    logic signed [W_E-1:0] e_q [3];
    logic signed [W_E-1:0] e_d [3];
    logic signed [W_E-1:0] ysc_q [3];
    logic signed [W_E-1:0] ysc_d [3];

    // Shared multiplier datapath: magnitudes only, sign applied at the end
    logic [W_E-1:0]        mcand_q, mcand_d;
    logic [11:0]           mplier_q, mplier_d;
    logic [W_E-1:0]        prod_q, prod_d;
    logic                  neg_q, neg_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;

    logic                  trigger;
    logic                  step_line;
    logic signed [10:0]    op_a;
    logic signed [11:0]    op_b;
    logic [10:0]           a_mag;
    logic [11:0]           b_mag;
    logic [W_E-1:0]        prod_step;
    logic [W_E-1:0]        prod_fin;

    // Beam-position events: setup trigger and per-line raster load column
    always_comb begin
        trigger   = (x == 10'd0) && (y == V_ACTIVE_Y);
        step_line = (x == H_LAST_X) && ((y < V_ACTIVE_Y) || (y == V_LAST_Y));
    end

    // Select the operand pair for the current product and form one shift-add step
    always_comb begin
        op_a = xs_q[0];
        op_b = dy_q[0];
        case (idx_q)
            3'd0: begin op_a = xs_q[0]; op_b = dy_q[0]; end
            3'd1: begin op_a = ys_q[0]; op_b = dx_q[0]; end
            3'd2: begin op_a = xs_q[1]; op_b = dy_q[1]; end
            3'd3: begin op_a = ys_q[1]; op_b = dx_q[1]; end
            3'd4: begin op_a = xs_q[2]; op_b = dy_q[2]; end
            default: begin op_a = ys_q[2]; op_b = dx_q[2]; end
        endcase
        a_mag     = op_a[10] ? 11'(-op_a) : 11'(op_a);
        b_mag     = op_b[11] ? 12'(-op_b) : 12'(op_b);
        prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
        prod_fin  = neg_q ? (-prod_step) : prod_step;
    end

    // Setup sequencer, multiply-accumulate and line stepping
    always_comb begin
        state_d  = state_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        acc_d    = acc_q;
        e_d      = e_q;
        ysc_d    = ysc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    xs_d[0] = x_v0;
                    xs_d[1] = x_v1;
                    xs_d[2] = x_v2;
                    ys_d[0] = y_v0;
                    ys_d[1] = y_v1;
                    ys_d[2] = y_v2;
                    state_d = S_LATCH;
                end else if (step_line) begin
                    for (int i = 0; i < 3; i++) begin
                        e_d[i] = e_q[i] - {{(W_E-12){dx_q[i][11]}}, dx_q[i]};
                    end
                end
            end

            S_LATCH: begin
                dx_d[0] = {xs_q[1][10], xs_q[1]} - {xs_q[0][10], xs_q[0]};
                dx_d[1] = {xs_q[2][10], xs_q[2]} - {xs_q[1][10], xs_q[1]};
                dx_d[2] = {xs_q[0][10], xs_q[0]} - {xs_q[2][10], xs_q[2]};
                dy_d[0] = {ys_q[1][10], ys_q[1]} - {ys_q[0][10], ys_q[0]};
                dy_d[1] = {ys_q[2][10], ys_q[2]} - {ys_q[1][10], ys_q[1]};
                dy_d[2] = {ys_q[0][10], ys_q[0]} - {ys_q[2][10], ys_q[2]};
                for (int i = 0; i < 3; i++) begin
                    acc_d[i] = '0;
                end
                cnt_d   = 4'd0;
                idx_d   = 3'd0;
                state_d = S_MUL;
            end

            S_MUL: begin
                if (cnt_q == 4'd0) begin
                    mcand_d  = {{(W_E-11){1'b0}}, a_mag};
                    mplier_d = b_mag;
                    prod_d   = '0;
                    neg_d    = op_a[10] ^ op_b[11];
                    cnt_d    = 4'd1;
                end else begin
                    prod_d   = prod_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == 4'd12) begin
                        // Even products are x*dy (subtracted), odd are y*dx (added)
                        for (int i = 0; i < 3; i++) begin
                            if (idx_q[2:1] == 2'(i)) begin
                                acc_d[i] = idx_q[0] ? (acc_q[i] + prod_fin)
                                                    : (acc_q[i] - prod_fin);
                            end
                        end
                        cnt_d = 4'd0;
                        if (idx_q == 3'd5) begin
                            state_d = S_COMMIT;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            S_COMMIT: begin
                for (int i = 0; i < 3; i++) begin
                    e_d[i]   = acc_q[i];
                    ysc_d[i] = {{(W_E-11){ys_q[i][10]}}, ys_q[i]};
                end
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                xs_q[i]  <= '0;
                ys_q[i]  <= '0;
                dx_q[i]  <= '0;
                dy_q[i]  <= '0;
                acc_q[i] <= '0;
                e_q[i]   <= '0;
                ysc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            for (int i = 0; i < 3; i++) begin
                xs_q[i]  <= xs_d[i];
                ys_q[i]  <= ys_d[i];
                dx_q[i]  <= dx_d[i];
                dy_q[i]  <= dy_d[i];
                acc_q[i] <= acc_d[i];
                e_q[i]   <= e_d[i];
                ysc_q[i] <= ysc_d[i];
            end
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign e0_init_t1  = e_q[0];
    assign e1_init_t1  = e_q[1];
    assign e2_init_t1  = e_q[2];
    assign y_screen_v0 = ysc_q[0];
    assign y_screen_v1 = ysc_q[1];
    assign y_screen_v2 = ysc_q[2];

endmodule
